// File: rtl/nz_index_scheduler_pkg.sv
// Shared types for the nonzero-index scheduler: FSM state encoding and default sizing.
package nz_index_scheduler_pkg;

  localparam int DEFAULT_BIT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage : nz_index_scheduler_pkg

// File: rtl/nz_index_scheduler_lnzd_range.sv
// Leading-nonzero detector restricted to an inclusive window [start, stop].
// Also exports the window mask so the caller can test for remaining bits.
module nz_index_scheduler_lnzd_range
  import nz_index_scheduler_pkg::*;
#(
  parameter  int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  localparam int IDX_WIDTH = $clog2(BIT_WIDTH)
) (
  input  logic [BIT_WIDTH-1:0] work,
  input  logic [IDX_WIDTH-1:0] start,
  input  logic [IDX_WIDTH-1:0] stop,
  output logic [BIT_WIDTH-1:0] mask,
  output logic [IDX_WIDTH-1:0] position,
  output logic                 valid
);

  // NOTE: every output gets a default before the loops so no latch is inferred.
  always_comb begin
    mask     = '0;
    position = '0;
    valid    = 1'b0;
    // start > stop leaves the mask empty, which reports valid=0.
    for (int i = 0; i < BIT_WIDTH; i++) begin
      if (i >= int'(start) && i <= int'(stop)) mask[i] = 1'b1;
    end
    // Ascending sweep: the highest set bit overwrites earlier hits.
    for (int i = 0; i < BIT_WIDTH; i++) begin
      if (work[i] && mask[i]) begin
        position = IDX_WIDTH'(i);
        valid    = 1'b1;
      end
    end
  end

endmodule : nz_index_scheduler_lnzd_range

// File: rtl/nz_index_scheduler.sv
// Enumerates set bits of a latched vector inside [start, stop], highest first,
// one index per accepted beat; empty windows yield a single out_empty beat.
module nz_index_scheduler
  import nz_index_scheduler_pkg::*;
#(
  parameter  int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  localparam int IDX_WIDTH = $clog2(BIT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic [IDX_WIDTH-1:0] in_start,
  input  logic [IDX_WIDTH-1:0] in_stop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_WIDTH-1:0] out_pos,
  output logic                 out_last,
  output logic                 out_empty,
  output logic [IDX_WIDTH:0]   out_count
);

  state_t               state, state_next;
  logic [BIT_WIDTH-1:0] work;
  logic [IDX_WIDTH-1:0] start, stop;
  logic [BIT_WIDTH-1:0] mask;
  logic [IDX_WIDTH-1:0] lnzd_pos;
  logic                 lnzd_valid;
  logic                 accept, fire;

  nz_index_scheduler_lnzd_range #(.BIT_WIDTH(BIT_WIDTH)) lnzd_range (
    .work    (work),
    .start   (start),
    .stop    (stop),
    .mask    (mask),
    .position(lnzd_pos),
    .valid   (lnzd_valid)
  );

  // rst_n gates in_ready so no job can be offered while reset is held.
  assign in_ready  = rst_n && (state == ST_IDLE) && !abort;
  assign out_valid = (state == ST_SCAN);
  assign out_empty = out_valid && !lnzd_valid;
  assign out_pos   = out_empty ? '0 : lnzd_pos;
  assign out_last  = out_valid &&
                     (out_empty || !(|(work & mask & ~(BIT_WIDTH'(1) << lnzd_pos))));
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept) state_next = ST_SCAN;
      ST_SCAN: if (abort || (fire && out_last)) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      work      <= '0;
      start     <= '0;
      stop      <= '0;
      out_count <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        work      <= in_data;
        start     <= in_start;
        stop      <= in_stop;
        out_count <= '0;
      end else if (out_valid && abort) begin
        work <= '0;
      end else if (fire) begin
        work      <= work & ~(BIT_WIDTH'(1) << lnzd_pos);
        out_count <= out_count + 1'b1;
      end
    end
  end

endmodule : nz_index_scheduler

// File: tb/tb_nz_index_scheduler.sv
// Self-checking bench: directed vector table, hand-written abort/reset/back-to-back
// sequences, and random jobs scored against a window-walk reference model.
module tb_nz_index_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_start, in_stop;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_pos;
  logic       out_last;
  logic       out_empty;
  logic [3:0] out_count;

  int tests = 0;
  int failures = 0;

  nz_index_scheduler #(.BIT_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_start (in_start),
    .in_stop  (in_stop),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pos  (out_pos),
    .out_last (out_last),
    .out_empty(out_empty),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      d;
    logic [2:0]      s;
    logic [2:0]      e;
    int              n;
    logic [7:0][2:0] pos;
    int              stall;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk the window from stop down to start, collecting set bits.
  task automatic model(input logic [7:0] d, input logic [2:0] s, input logic [2:0] e,
                       output int n, output logic [7:0][2:0] pos);
    n   = 0;
    pos = '0;
    for (int i = 7; i >= 0; i--) begin
      if (i >= int'(s) && i <= int'(e) && d[i]) begin
        pos[n] = 3'(i);
        n++;
      end
    end
  endtask

  task automatic run_job(input logic [7:0] d, input logic [2:0] s, input logic [2:0] e,
                         input int n, input logic [7:0][2:0] exp_pos,
                         input int stall_first, input bit rand_ready, input string tag);
    int k, cyc, beats;
    bit empty_job;
    empty_job = (n == 0);
    beats     = empty_job ? 1 : n;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_start = s; in_stop = e; out_ready = 1'b0;
    #1 check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'($urandom);
    k = 0; cyc = 0;
    while (k < beats && cyc < 200) begin
      if (cyc < stall_first)  out_ready = 1'b0;
      else if (rand_ready)    out_ready = 1'($urandom_range(0, 1));
      else                    out_ready = 1'b1;
      #1;
      check({tag, "_valid"}, 32'(out_valid), 32'(1));
      check({tag, "_pos"},   32'(out_pos),   32'(empty_job ? 3'd0 : exp_pos[k]));
      check({tag, "_last"},  32'(out_last),  32'(k == beats - 1));
      check({tag, "_empty"}, 32'(out_empty), 32'(empty_job));
      check({tag, "_count"}, 32'(out_count), 32'(k));
      if (out_ready) k++;
      cyc++;
      @(negedge clk);
    end
    if (k < beats) check({tag, "_timeout"}, 32'(k), 32'(beats));
    #1;
    check({tag, "_done_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_done_ready"}, 32'(in_ready),  32'(1));
  endtask

  initial begin
    int n;
    logic [7:0][2:0] pos;
    logic [7:0] d;
    logic [2:0] s, e;

    vecs[0] = '{8'hA6, 3'd0, 3'd7, 4, {3'd0,3'd0,3'd0,3'd0,3'd1,3'd2,3'd5,3'd7}, 0};
    vecs[1] = '{8'hFF, 3'd2, 3'd4, 3, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd2,3'd3,3'd4}, 0};
    vecs[2] = '{8'h0F, 3'd4, 3'd7, 0, '0, 0};
    vecs[3] = '{8'hFF, 3'd5, 3'd3, 0, '0, 0};
    vecs[4] = '{8'hA6, 3'd0, 3'd7, 4, {3'd0,3'd0,3'd0,3'd0,3'd1,3'd2,3'd5,3'd7}, 3};

    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    in_start = '0; in_stop = '0; out_ready = 1'b1;
    #3;
    check("rst_in_ready",  32'(in_ready),  32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_last",  32'(out_last),  32'(0));
    check("rst_out_empty", 32'(out_empty), 32'(0));
    check("rst_out_pos",   32'(out_pos),   32'(0));
    check("rst_out_count", 32'(out_count), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_in_ready", 32'(in_ready), 32'(1));

    for (int i = 0; i < 5; i++)
      run_job(vecs[i].d, vecs[i].s, vecs[i].e, vecs[i].n, vecs[i].pos, vecs[i].stall, 1'b0,
              $sformatf("vec%0d", i));

    // Abort in the cycle after the first fire.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hA6; in_start = 3'd0; in_stop = 3'd7; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("abt_first_pos", 32'(out_pos), 32'(7));
    @(negedge clk);
    abort = 1'b1;
    #1 check("abt_pos_before", 32'(out_pos), 32'(5));
    check("abt_in_ready_low", 32'(in_ready), 32'(0));
    @(negedge clk);
    abort = 1'b0;
    #1 check("abt_out_valid", 32'(out_valid), 32'(0));
    check("abt_in_ready", 32'(in_ready), 32'(1));

    // Abort in IDLE blocks a simultaneous request.
    @(negedge clk);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    #1 check("abt_idle_in_ready", 32'(in_ready), 32'(0));
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    #1 check("abt_idle_no_job", 32'(out_valid), 32'(0));

    // Reset in the middle of a scan.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hA6; in_start = 3'd0; in_stop = 3'd7; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_in_ready", 32'(in_ready), 32'(0));
    check("mid_rst_out_pos", 32'(out_pos), 32'(0));
    check("mid_rst_out_count", 32'(out_count), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_job(vecs[0].d, vecs[0].s, vecs[0].e, vecs[0].n, vecs[0].pos, 0, 1'b0, "after_rst");

    // in_valid held across two jobs: second accepted only after first's last fire.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h81; in_start = 3'd0; in_stop = 3'd7; out_ready = 1'b1;
    @(negedge clk);
    in_data = 8'h10;
    #1 check("b2b_busy_ready", 32'(in_ready), 32'(0));
    check("b2b_pos0", 32'(out_pos), 32'(7));
    check("b2b_last0", 32'(out_last), 32'(0));
    @(negedge clk);
    #1 check("b2b_pos1", 32'(out_pos), 32'(0));
    check("b2b_last1", 32'(out_last), 32'(1));
    check("b2b_count1", 32'(out_count), 32'(1));
    @(negedge clk);
    #1 check("b2b_idle_valid", 32'(out_valid), 32'(0));
    check("b2b_idle_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("b2b_job2_pos", 32'(out_pos), 32'(4));
    check("b2b_job2_last", 32'(out_last), 32'(1));
    check("b2b_job2_empty", 32'(out_empty), 32'(0));
    check("b2b_job2_count", 32'(out_count), 32'(0));
    @(negedge clk);
    #1 check("b2b_done", 32'(out_valid), 32'(0));

    // Random jobs with random backpressure.
    for (int j = 0; j < 40; j++) begin
      d = 8'($urandom);
      s = 3'($urandom_range(0, 7));
      e = 3'($urandom_range(0, 7));
      if (j == 0) begin d = 8'hFF; s = 3'd0; e = 3'd7; end
      model(d, s, e, n, pos);
      run_job(d, s, e, n, pos, 0, 1'b1, $sformatf("rnd%0d", j));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule : tb_nz_index_scheduler
